// File: rtl/pred_regfile_sb_if.sv
// -----------------------------------------------------------------------------
// pred_regfile_sb_if
//   Bundles the reserve, writeback, flush, read, guard and status signals of the
//   predicate register file / scoreboard.
//   master : issue/exec/decode side (drives reserve, writeback, flush and the
//            read/guard indices; observes read/guard results and status).
//   slave  : the pred_regfile_sb block itself.
// Parameters
//   PIDX_W  predicate index width
//   CNT_W   pending-count width
// -----------------------------------------------------------------------------
interface pred_regfile_sb_if #(
  parameter int PIDX_W = 3,
  parameter int CNT_W  = 4
);
  logic              rsv_valid;
  logic [PIDX_W-1:0] rsv_idx;
  logic              wb_valid;
  logic [PIDX_W-1:0] wb_idx;
  logic              wb_data;
  logic              flush;
  logic [PIDX_W-1:0] rd0_idx;
  logic              rd0_data;
  logic              rd0_ready;
  logic [PIDX_W-1:0] rd1_idx;
  logic              rd1_data;
  logic              rd1_ready;
  logic [PIDX_W-1:0] grd_idx;
  logic              grd_neg;
  logic              grd_pass;
  logic              grd_ready;
  logic [CNT_W-1:0]  pend_cnt;
  logic              sb_err;

  modport master (
    output rsv_valid, rsv_idx, wb_valid, wb_idx, wb_data, flush,
    output rd0_idx, rd1_idx, grd_idx, grd_neg,
    input  rd0_data, rd0_ready, rd1_data, rd1_ready,
    input  grd_pass, grd_ready, pend_cnt, sb_err
  );

  modport slave (
    input  rsv_valid, rsv_idx, wb_valid, wb_idx, wb_data, flush,
    input  rd0_idx, rd1_idx, grd_idx, grd_neg,
    output rd0_data, rd0_ready, rd1_data, rd1_ready,
    output grd_pass, grd_ready, pend_cnt, sb_err
  );
endinterface

// File: rtl/pred_regfile_sb.sv
// -----------------------------------------------------------------------------
// pred_regfile_sb
//   Predicate register file plus scoreboard. Holds NUM_PREGS one-bit predicates
//   (p0 hardwired true). Issue reserves a destination (marks it pending), the
//   predicate ALU writeback fills it and clears pending. Two source read ports
//   and one guard port are combinational from state and report readiness so
//   decode/issue can stall on pending sources.
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   pif   pred_regfile_sb_if.slave:
//           rsv_valid/rsv_idx          reserve a destination
//           wb_valid/wb_idx/wb_data    writeback of a predicate result
//           flush                      drop every outstanding reservation
//           rdN_idx -> rdN_data/ready  source reads (N = 0,1)
//           grd_idx/grd_neg -> grd_pass/grd_ready   instruction guard
//           pend_cnt                   number of pending predicates
//           sb_err                     sticky protocol error
// Configuration
//   PRED_BYPASS_EN  when defined, a same-cycle writeback is forwarded to the
//                   read and guard ports (value and ready=1). When undefined
//                   the ports see registered state only.
// -----------------------------------------------------------------------------
module pred_regfile_sb #(
  parameter int NUM_PREGS = 8,
  parameter int PIDX_W    = 3,
  parameter int CNT_W     = 4
) (
  input logic             clk,
  input logic             rst,
  pred_regfile_sb_if.slave pif
);

  // Architectural state. Bit 0 of every vector stays 0: p0 is synthesised on read.
  logic [NUM_PREGS-1:0] data_q;
  logic [NUM_PREGS-1:0] pend_q;
  // A set bit means an in-flight producer for this register was dropped by a
  // flush; its late writeback is still legal even though nothing is pending.
  logic [NUM_PREGS-1:0] flsh_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 err_q;

  logic [NUM_PREGS-1:0] rsv_hit;
  logic [NUM_PREGS-1:0] wb_hit;
  logic [NUM_PREGS-1:0] data_n;
  logic [NUM_PREGS-1:0] pend_n;
  logic [NUM_PREGS-1:0] flsh_n;
  logic                 err_set;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PREGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_PREGS; k++) c = c + CNT_W'(v[k]);
    return c;
  endfunction

  // Returns {ready, data} for one read/guard port.
  function automatic logic [1:0] read_port(
    input logic [PIDX_W-1:0]    idx,
    input logic [NUM_PREGS-1:0] d,
    input logic [NUM_PREGS-1:0] p,
    input logic                 wv,
    input logic [PIDX_W-1:0]    wi,
    input logic                 wd
  );
    logic [1:0] r;
    if (idx == '0) begin
      r = 2'b11;
    end else begin
      r = {~p[idx], d[idx]};
`ifdef PRED_BYPASS_EN
      if (wv && (wi == idx)) r = {1'b1, wd};
`endif
    end
    return r;
  endfunction

  // Decode reserve/writeback targets; p0 never matches.
  always_comb begin
    rsv_hit = '0;
    wb_hit  = '0;
    for (int k = 1; k < NUM_PREGS; k++) begin
      rsv_hit[k] = pif.rsv_valid && (pif.rsv_idx == PIDX_W'(k));
      wb_hit[k]  = pif.wb_valid  && (pif.wb_idx  == PIDX_W'(k));
    end
  end

  // Next-state. Reserve is ORed in after the writeback clear so that a
  // same-cycle reserve+writeback leaves the register pending for the new
  // producer. A flush clears everything and drops the same-cycle reserve.
  always_comb begin
    data_n = (data_q & ~wb_hit) | (wb_hit & {NUM_PREGS{pif.wb_data}});
    if (pif.flush) pend_n = '0;
    else           pend_n = (pend_q & ~wb_hit) | rsv_hit;

    flsh_n = flsh_q;
    if (pif.flush) flsh_n = flsh_n | pend_q;
    flsh_n = flsh_n & ~wb_hit;
    if (!pif.flush) flsh_n = flsh_n & ~rsv_hit;

    err_set = 1'b0;
    if (!pif.flush && |(rsv_hit & pend_q & ~wb_hit)) err_set = 1'b1;
    if (|(wb_hit & ~pend_q & ~flsh_q))                err_set = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= '0;
      flsh_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_n;
      pend_q <= pend_n;
      flsh_q <= flsh_n;
      cnt_q  <= popcount(pend_n);
      if (err_set) err_q <= 1'b1;
    end
  end

  // Combinational read/guard ports from registered state (plus optional bypass).
  logic [1:0] rd0_r, rd1_r, grd_r;

  always_comb begin
    rd0_r = read_port(pif.rd0_idx, data_q, pend_q, pif.wb_valid, pif.wb_idx, pif.wb_data);
    rd1_r = read_port(pif.rd1_idx, data_q, pend_q, pif.wb_valid, pif.wb_idx, pif.wb_data);
    grd_r = read_port(pif.grd_idx, data_q, pend_q, pif.wb_valid, pif.wb_idx, pif.wb_data);
  end

  assign pif.rd0_data  = rd0_r[0];
  assign pif.rd0_ready = rd0_r[1];
  assign pif.rd1_data  = rd1_r[0];
  assign pif.rd1_ready = rd1_r[1];
  assign pif.grd_pass  = grd_r[0] ^ pif.grd_neg;
  assign pif.grd_ready = grd_r[1];
  assign pif.pend_cnt  = cnt_q;
  assign pif.sb_err    = err_q;

endmodule

// File: tb/tb_pred_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_pred_regfile_sb
//   Scoreboard bench for pred_regfile_sb. A driver applies one stimulus vector
//   per cycle, predicts the cycle's outputs from a behavioural model of the
//   predicate file, and queues the prediction; a monitor on the falling edge
//   pops and compares. Directed sequences are followed by constrained-random
//   traffic with periodic resets.
// -----------------------------------------------------------------------------
module tb_pred_regfile_sb;
  localparam int NP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pred_regfile_sb_if #(.PIDX_W(3), .CNT_W(4)) pif ();

  pred_regfile_sb #(.NUM_PREGS(NP), .PIDX_W(3), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  typedef struct {
    int       step;
    bit       rd0_data, rd0_ready, rd1_data, rd1_ready;
    bit       grd_pass, grd_ready, sb_err;
    int       pend_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step   = 0;

  // Reference model: plain arrays of predicate values and scoreboard flags.
  bit m_val [NP];
  bit m_pend[NP];
  bit m_dropped[NP];
  bit m_err;

  function automatic void model_reset();
    for (int k = 0; k < NP; k++) begin
      m_val[k] = 0; m_pend[k] = 0; m_dropped[k] = 0;
    end
    m_err = 0;
  endfunction

  // Value/readiness the pipeline would see for predicate i this cycle.
  function automatic void model_read(input int i, input bit wv, input int wi, input bit wd,
                                     output bit d, output bit r);
    if (i == 0) begin
      d = 1; r = 1;
    end else begin
      d = m_val[i]; r = !m_pend[i];
`ifdef PRED_BYPASS_EN
      if (wv && wi == i) begin d = wd; r = 1; end
`endif
    end
  endfunction

  function automatic void model_step(input bit rv, input int ri, input bit wv, input int wi,
                                     input bit wd, input bit fl);
    bit rsv_ok, wb_ok;
    rsv_ok = rv && ri != 0;
    wb_ok  = wv && wi != 0;
    // Reserving a register that already has a live producer is a protocol error,
    // unless that producer retires in the same cycle or the reserve is flushed.
    if (rsv_ok && !fl && m_pend[ri] && !(wb_ok && wi == ri)) m_err = 1;
    // A writeback must have a live or flush-dropped producer.
    if (wb_ok && !m_pend[wi] && !m_dropped[wi]) m_err = 1;
    if (fl) for (int k = 0; k < NP; k++) if (m_pend[k]) m_dropped[k] = 1;
    if (wb_ok) m_dropped[wi] = 0;
    if (rsv_ok && !fl) m_dropped[ri] = 0;
    if (wb_ok) m_val[wi] = wd;
    if (fl) begin
      for (int k = 0; k < NP; k++) m_pend[k] = 0;
    end else begin
      if (wb_ok) m_pend[wi] = 0;
      if (rsv_ok) m_pend[ri] = 1;
    end
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int k = 0; k < NP; k++) c += m_pend[k];
    return c;
  endfunction

  // One clock of stimulus: drive, predict, queue, advance the model.
  task automatic cyc(input bit r, input bit rv, input int ri, input bit wv, input int wi,
                     input bit wd, input bit fl, input int a0, input int a1,
                     input int g, input bit gn);
    exp_t e;
    bit gd;
    @(posedge clk);
    #1;
    rst           = r;
    pif.rsv_valid = rv;   pif.rsv_idx = 3'(ri);
    pif.wb_valid  = wv;   pif.wb_idx  = 3'(wi);  pif.wb_data = wd;
    pif.flush     = fl;
    pif.rd0_idx   = 3'(a0); pif.rd1_idx = 3'(a1);
    pif.grd_idx   = 3'(g);  pif.grd_neg = gn;
    if (r) model_reset();
    step++;
    e.step = step;
    model_read(a0, wv, wi, wd, e.rd0_data, e.rd0_ready);
    model_read(a1, wv, wi, wd, e.rd1_data, e.rd1_ready);
    model_read(g,  wv, wi, wd, gd, e.grd_ready);
    e.grd_pass = gd ^ gn;
    e.pend_cnt = model_cnt();
    e.sb_err   = m_err;
    exp_q.push_back(e);
    if (!r) model_step(rv, ri, wv, wi, wd, fl);
  endtask

  task automatic idle(input int a0, input int a1, input int g, input bit gn);
    cyc(0, 0, 0, 0, 0, 0, 0, a0, a1, g, gn);
  endtask

  task automatic chk(input string name, input int stp, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, stp, act, req);
    end
  endtask

  // Monitor: the DUT presents its read/guard/status outputs every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd0_data",  e.step, int'(pif.rd0_data),  int'(e.rd0_data));
      chk("rd0_ready", e.step, int'(pif.rd0_ready), int'(e.rd0_ready));
      chk("rd1_data",  e.step, int'(pif.rd1_data),  int'(e.rd1_data));
      chk("rd1_ready", e.step, int'(pif.rd1_ready), int'(e.rd1_ready));
      chk("grd_ready", e.step, int'(pif.grd_ready), int'(e.grd_ready));
      if (e.grd_ready) chk("grd_pass", e.step, int'(pif.grd_pass), int'(e.grd_pass));
      chk("pend_cnt",  e.step, int'(pif.pend_cnt),  e.pend_cnt);
      chk("sb_err",    e.step, int'(pif.sb_err),    int'(e.sb_err));
    end
  end

  initial begin
    pif.rsv_valid = 0; pif.rsv_idx = '0; pif.wb_valid = 0; pif.wb_idx = '0;
    pif.wb_data = 0; pif.flush = 0; pif.rd0_idx = '0; pif.rd1_idx = '0;
    pif.grd_idx = '0; pif.grd_neg = 0;
    model_reset();

    // Reset state with a spread of read indices.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 3, 5, 0);
    idle(0, 3, 0, 1);

    // Reset mid-run with p3 pending.
    cyc(0, 1, 3, 0, 0, 0, 0, 3, 0, 3, 0);
    idle(3, 3, 3, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 3, 3, 0);
    idle(3, 0, 3, 1);

    // Reserve p2, observe pending, write back 1.
    cyc(0, 1, 2, 0, 0, 0, 0, 2, 0, 2, 0);
    idle(2, 2, 2, 0);
    cyc(0, 0, 0, 1, 2, 1, 0, 2, 2, 2, 0);
    idle(2, 2, 2, 1);

    // Guard on p5 = 1 with and without inversion, and on p0.
    cyc(0, 1, 5, 0, 0, 0, 0, 5, 0, 5, 0);
    cyc(0, 0, 0, 1, 5, 1, 0, 5, 0, 5, 1);
    idle(5, 5, 5, 1);
    idle(5, 0, 5, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 1);

    // Reserve and writeback of the same pending register in one cycle.
    cyc(0, 1, 4, 0, 0, 0, 0, 4, 0, 4, 0);
    cyc(0, 1, 4, 1, 4, 1, 0, 4, 4, 4, 0);
    idle(4, 4, 4, 0);
    cyc(0, 0, 0, 1, 4, 0, 0, 4, 4, 4, 0);
    idle(4, 4, 4, 0);

    // Flush with a same-cycle reserve, then a late writeback of a dropped reg.
    cyc(0, 1, 1, 0, 0, 0, 0, 1, 6, 7, 0);
    cyc(0, 1, 6, 0, 0, 0, 0, 1, 6, 7, 0);
    cyc(0, 1, 7, 0, 0, 0, 1, 1, 6, 7, 0);
    idle(1, 6, 7, 0);
    cyc(0, 0, 0, 1, 6, 1, 0, 6, 7, 6, 0);
    idle(6, 1, 6, 1);

    // Reserve/writeback of p0 are ignored.
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 1, 0, 0);

    // Writeback to a never-reserved register raises a sticky error.
    cyc(0, 0, 0, 1, 3, 1, 0, 3, 0, 3, 0);
    idle(3, 2, 3, 0);
    cyc(0, 1, 3, 0, 0, 0, 0, 3, 0, 3, 0);
    cyc(0, 0, 0, 1, 3, 0, 0, 3, 0, 3, 0);
    idle(3, 0, 3, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0);
    idle(3, 0, 3, 0);

    // Constrained-random traffic; mostly legal, occasional protocol errors.
    for (int n = 0; n < 400; n++) begin
      bit rv, wv, wd, fl, gn, r;
      int ri, wi;
      r  = (n % 80) == 79;
      fl = ($urandom_range(0, 19) == 0);
      rv = $urandom_range(0, 1);
      ri = $urandom_range(0, NP - 1);
      if (rv && m_pend[ri] && ($urandom_range(0, 29) != 0 || fl)) rv = 0;
      wv = $urandom_range(0, 1);
      wi = $urandom_range(0, NP - 1);
      if (wv && !m_pend[wi] && !m_dropped[wi] && $urandom_range(0, 29) != 0) wv = 0;
      wd = $urandom_range(0, 1);
      gn = $urandom_range(0, 1);
      if (r) begin rv = 0; wv = 0; fl = 0; end
      cyc(r, rv, ri, wv, wi, wd, fl, $urandom_range(0, NP - 1),
          $urandom_range(0, NP - 1), $urandom_range(0, NP - 1), gn);
    end

    idle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
